cache_dados_wb: RTL

- Direct-mapped, write-back, write-allocate data cache.
- Sits directly downstream of the multicycle MIPS core's Memory stage.
- Consumes the core's address/data/r_en/w_en.
- Returns read data and a stall flag.
- On a miss, fetches or evicts single-word lines to/from main data memory over a ready-handshake port.

---
 rtl/cache_dados_wb.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cache_dados_wb.sv
// cache_dados_wb: direct-mapped write-back write-allocate data cache with one-word lines (optional CACHE_STATS_EN adds hit/miss counters)
module cache_dados_wb #(
    parameter int ADDR_W  = 12,
    parameter int INDEX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data,
    input  logic              r_en,
    input  logic              w_en,
    output logic [31:0]       saida_cache,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [31:0]       mem_rdata,
`ifdef CACHE_STATS_EN
    input  logic              mem_ready,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`else
    input  logic              mem_ready
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 2 ** INDEX_W;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WB    = 2'd1;
    localparam logic [1:0] ST_ALLOC = 2'd2;

    logic [1:0]         r_state;
    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic [TAG_W-1:0]   r_tag [LINES];
    logic [31:0]        r_word [LINES];
    logic [ADDR_W-1:0]  r_req_addr;
    logic [ADDR_W-1:0]  r_mem_address;
    logic [31:0]        r_mem_wdata;
    logic               r_mem_rd;
    logic               r_mem_wr;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0]   w_fill_tag;
    logic               w_req;
    logic               w_hit;
    logic               w_idle;

    assign w_idx       = address[INDEX_W-1:0];
    assign w_tag       = address[ADDR_W-1:INDEX_W];
    assign w_fill_idx  = r_req_addr[INDEX_W-1:0];
    assign w_fill_tag  = r_req_addr[ADDR_W-1:INDEX_W];
    assign w_req       = r_en | w_en;
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_idle      = (r_state == ST_IDLE);
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;

    // Zero-wait hit path: stall only on a miss or while a memory transaction is open
    always_comb begin
        stall       = !w_idle || (w_req && !w_hit);
        saida_cache = (w_idle && r_en && !w_en && w_hit) ? r_word[w_idx] : '0;
    end

    // Miss FSM, line status bits and the registered memory port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_valid       <= '0;
            r_dirty       <= '0;
            r_req_addr    <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_en && w_hit) begin
                        r_dirty[w_idx] <= 1'b1;
                    end else if (w_req && !w_hit) begin
                        r_req_addr <= address;
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state       <= ST_WB;
                            r_mem_wr      <= 1'b1;
                            r_mem_address <= {r_tag[w_idx], w_idx};
                            r_mem_wdata   <= r_word[w_idx];
                        end else begin
                            r_state       <= ST_ALLOC;
                            r_mem_rd      <= 1'b1;
                            r_mem_address <= address;
                        end
                    end
                end
                ST_WB: begin
                    if (mem_ready) begin
                        r_dirty[w_fill_idx] <= 1'b0;
                        r_mem_wr            <= 1'b0;
                        r_mem_rd            <= 1'b1;
                        r_mem_address       <= r_req_addr;
                        r_state             <= ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    if (mem_ready) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_dirty[w_fill_idx] <= 1'b0;
                        r_mem_rd            <= 1'b0;
                        r_state             <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Tag and data arrays need no reset; validity is tracked by r_valid
    always_ff @(posedge clk) begin
        if (w_idle && w_en && w_hit) begin
            r_word[w_idx] <= data;
        end else if (r_state == ST_ALLOC && mem_ready) begin
            r_word[w_fill_idx] <= mem_rdata;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;
    logic        r_refill;

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // Saturating counters; the access completing right after a fill was already counted as a miss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_refill     <= 1'b0;
        end else begin
            r_refill <= (r_state == ST_ALLOC) && mem_ready;
            if (w_idle && w_req && w_hit && !r_refill && r_hit_count != 16'hFFFF)
                r_hit_count <= r_hit_count + 16'd1;
            if (w_idle && w_req && !w_hit && r_miss_count != 16'hFFFF)
                r_miss_count <= r_miss_count + 16'd1;
        end
    end
`endif
endmodule
